mux4_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters. Each requester raises `req[i]` to take the shared path. The block picks one owner, drives the mux select, and forwards that owner's data word to `dout`. A hold limit stops any single owner from starving the others. The block sits in front of the combinational mux path and is the only driver of its select lines.

---
 rtl/mux4_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select of a shared
// 4:1 data multiplexer and forwards the current owner's word to dout.
// A hold limit pre-empts an owner that keeps the path while others wait.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - request lines, req[i] high = requester i wants the path
//   din    - packed data, requester i drives din[i*WIDTH +: WIDTH]
//   gnt    - registered one-hot grant, zero when idle
//   sel    - registered mux select (index of current owner)
//   busy   - registered, high while a grant is active
//   dout   - combinational, selected data word when busy, else 0
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [WIDTH-1:0]   dout
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [3:0] hold_cnt, hold_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n;
  logic       busy_n;

  logic [1:0] k_idle;
  logic [1:0] k_next;
  logic [3:0] others;
  logic       own_req;

  // First requesting index scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] pick(input logic [1:0] start,
                                      input logic [3:0] r);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Candidate winners: from the rotation pointer when idle, and from the
  // index after the owner on hand-off (the owner is scanned last, so a
  // pre-empt with another request pending never re-picks the owner).
  always_comb begin
    k_idle  = pick(ptr, req);
    k_next  = pick(sel + 2'd1, req);
    others  = req & ~(4'b0001 << sel);
    own_req = req[sel];
  end

  // Next-state and next-output decision.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    busy_n  = busy;

    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << k_idle;
          sel_n   = k_idle;
          busy_n  = 1'b1;
          hold_n  = 4'd1;
          ptr_n   = k_idle + 2'd1;
        end
      end

      GRANT: begin
        if (!own_req) begin
          if (|others) begin
            // Release with a waiter: hand off on the same edge.
            gnt_n  = 4'b0001 << k_next;
            sel_n  = k_next;
            hold_n = 4'd1;
            ptr_n  = k_next + 2'd1;
          end else begin
            // Release with nobody waiting: sel and ptr keep their values.
            state_n = IDLE;
            gnt_n   = 4'b0000;
            busy_n  = 1'b0;
            hold_n  = 4'd0;
          end
        end else if ((hold_cnt >= HOLD_MAX) && (|others)) begin
          // Hold limit reached while contended: pre-empt.
          gnt_n  = 4'b0001 << k_next;
          sel_n  = k_next;
          hold_n = 4'd1;
          ptr_n  = k_next + 2'd1;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_n = hold_cnt + 4'd1;
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
        hold_n  = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
    end
  end

  // Shared data path: forward the owner's slice while a grant is active.
  always_comb begin
    dout = '0;
    if (busy) begin
      case (sel)
        2'd0:    dout = din[0*WIDTH +: WIDTH];
        2'd1:    dout = din[1*WIDTH +: WIDTH];
        2'd2:    dout = din[2*WIDTH +: WIDTH];
        default: dout = din[3*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule
